// File: rtl/pulse_measure.sv
// Measures arm-to-rising-edge delay and high width of an asynchronous pulse, one result per arm.
// Latency: result_valid registered, a fixed number of cycles after the falling sample; counts exact.
// Backpressure: result held frozen in DONE until result_ready; arm ignored outside IDLE.
module pulse_measure #(
    parameter int COUNT_WIDTH = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   arm,
    input  logic                   pulse_in,
    output logic                   busy,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [COUNT_WIDTH-1:0] delay_count,
    output logic [COUNT_WIDTH-1:0] width_count,
    output logic                   overflow
);

    localparam int AW = $clog2(SYNC_STAGES);
    localparam logic [AW-1:0] ALIGN_LAST = AW'(SYNC_STAGES - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_LAST = {{(COUNT_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        WAIT_LOW,
        WAIT_RISE,
        MEASURE,
        DONE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [AW-1:0]          align_cnt;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            align_cnt    <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            delay_count  <= '0;
            width_count  <= '0;
            overflow     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm) begin
                        state       <= ALIGN;
                        align_cnt   <= '0;
                        busy        <= 1'b1;
                        delay_count <= '0;
                        width_count <= '0;
                        overflow    <= 1'b0;
                    end
                end
                // Burn the synchronizer latency so the first WAIT cycle sees the post-arm sample.
                ALIGN: begin
                    if (align_cnt == ALIGN_LAST) begin
                        state <= s ? WAIT_LOW : WAIT_RISE;
                    end else begin
                        align_cnt <= align_cnt + 1'b1;
                    end
                end
                WAIT_LOW: begin
                    if (delay_count == CNT_LAST) begin
                        delay_count  <= CNT_MAX;
                        overflow     <= 1'b1;
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end else begin
                        delay_count <= delay_count + 1'b1;
                        if (!s) begin
                            state <= WAIT_RISE;
                        end
                    end
                end
                WAIT_RISE: begin
                    if (s) begin
                        width_count <= CNT_ONE;
                        state       <= MEASURE;
                    end else if (delay_count == CNT_LAST) begin
                        delay_count  <= CNT_MAX;
                        overflow     <= 1'b1;
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end else begin
                        delay_count <= delay_count + 1'b1;
                    end
                end
                MEASURE: begin
                    if (!s) begin
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end else if (width_count == CNT_LAST) begin
                        width_count  <= CNT_MAX;
                        overflow     <= 1'b1;
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end else begin
                        width_count <= width_count + 1'b1;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_measure.sv
// Bench for pulse_measure: 16-bit and 8-bit instances share stimulus, results checked against a
// sample-sequence model of delay/width/overflow.
module tb_pulse_measure;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        arm;
    logic        pulse_in;
    logic        result_ready;

    logic        busy16, valid16, ovf16;
    logic [15:0] d16, w16;
    logic        busy8, valid8, ovf8;
    logic [7:0]  d8, w8;

    int total = 0;
    int bad   = 0;
    bit pat[$];

    always #5 clock = ~clock;

    pulse_measure #(.COUNT_WIDTH(16), .SYNC_STAGES(2)) u_dut16 (
        .clock(clock), .reset_n(reset_n), .arm(arm), .pulse_in(pulse_in),
        .busy(busy16), .result_valid(valid16), .result_ready(result_ready),
        .delay_count(d16), .width_count(w16), .overflow(ovf16)
    );

    pulse_measure #(.COUNT_WIDTH(8), .SYNC_STAGES(2)) u_dut8 (
        .clock(clock), .reset_n(reset_n), .arm(arm), .pulse_in(pulse_in),
        .busy(busy8), .result_valid(valid8), .result_ready(result_ready),
        .delay_count(d8), .width_count(w8), .overflow(ovf8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // q[0] is pulse_in at the arm edge, q[k] the k-th edge after; pulse_in is low beyond the end.
    // Delay counts every sample before the first low-to-high transition; width counts the high run.
    function automatic void model(input bit q[$], input int maxv,
                                  output int d, output int w, output bit o);
        int i = 1;
        int n = 0;
        d = 0; w = 0; o = 1'b0;
        while (i < q.size() && !(q[i] && !q[i-1])) i++;
        if (i >= q.size() || i - 1 >= maxv) begin
            d = maxv; o = 1'b1;
            return;
        end
        d = i - 1;
        while (i < q.size() && q[i]) begin n++; i++; end
        if (n >= maxv) begin w = maxv; o = 1'b1; end
        else w = n;
    endfunction

    task automatic measure(input string tag, input int hold);
        int d16e, w16e, d8e, w8e, cyc;
        bit o16e, o8e;
        model(pat, 65535, d16e, w16e, o16e);
        model(pat, 255, d8e, w8e, o8e);
        @(negedge clock); arm = 1'b1; pulse_in = pat[0];
        for (int k = 1; k < pat.size(); k++) begin
            @(negedge clock); arm = 1'b0; pulse_in = pat[k];
        end
        @(negedge clock); arm = 1'b0; pulse_in = 1'b0;
        cyc = 0;
        while (!(valid16 && valid8) && cyc < 100) begin
            @(negedge clock); cyc++;
        end
        check({tag, "_done"}, 32'(valid16 && valid8), 32'd1);
        check({tag, "_d16"}, 32'(d16), 32'(d16e));
        check({tag, "_w16"}, 32'(w16), 32'(w16e));
        check({tag, "_o16"}, 32'(ovf16), 32'(o16e));
        check({tag, "_d8"}, 32'(d8), 32'(d8e));
        check({tag, "_w8"}, 32'(w8), 32'(w8e));
        check({tag, "_o8"}, 32'(ovf8), 32'(o8e));
        for (int h = 0; h < hold; h++) begin
            arm = 1'($urandom_range(0, 1));
            @(negedge clock);
            check({tag, "_hold_v"}, 32'(valid16), 32'd1);
            check({tag, "_hold_d"}, 32'(d16), 32'(d16e));
            check({tag, "_hold_w"}, 32'(w16), 32'(w16e));
            check({tag, "_hold_o"}, 32'(ovf16), 32'(o16e));
        end
        // arm coincides with the accepting handshake and must not start a new measurement
        arm = 1'b1; result_ready = 1'b1;
        @(negedge clock);
        arm = 1'b0; result_ready = 1'b0;
        check({tag, "_hs_v16"}, 32'(valid16), 32'd0);
        check({tag, "_hs_b16"}, 32'(busy16), 32'd0);
        check({tag, "_hs_v8"}, 32'(valid8), 32'd0);
        check({tag, "_hs_b8"}, 32'(busy8), 32'd0);
        @(negedge clock);
        check({tag, "_idle_b16"}, 32'(busy16), 32'd0);
        check({tag, "_keep_d16"}, 32'(d16), 32'(d16e));
        check({tag, "_keep_w16"}, 32'(w16), 32'(w16e));
    endtask

    task automatic push_run(input bit v, input int n);
        for (int k = 0; k < n; k++) pat.push_back(v);
    endtask

    task automatic build_ref(input int dl, input int wd);
        pat.delete();
        push_run(1'b0, dl + 1);
        push_run(1'b1, wd);
        pat.push_back(1'b0);
    endtask

    initial begin
        int cyc;
        reset_n = 1'b0; arm = 1'b0; pulse_in = 1'b0; result_ready = 1'b0;

        // reset holds everything idle regardless of input activity
        for (int k = 0; k < 6; k++) begin
            @(negedge clock); arm = ~arm; pulse_in = ~pulse_in;
        end
        @(negedge clock);
        check("rst_busy", 32'(busy16 | busy8), 32'd0);
        check("rst_valid", 32'(valid16 | valid8), 32'd0);
        check("rst_d", 32'(d16) | 32'(d8), 32'd0);
        check("rst_w", 32'(w16) | 32'(w8), 32'd0);
        check("rst_ovf", 32'(ovf16 | ovf8), 32'd0);
        arm = 1'b0; pulse_in = 1'b0;
        @(negedge clock); reset_n = 1'b1;
        @(negedge clock);

        build_ref(511, 15);
        measure("dly511", 0);

        pat.delete();
        push_run(1'b1, 6); push_run(1'b0, 3); push_run(1'b1, 4); pat.push_back(1'b0);
        measure("high_at_arm", 20);

        // 8-bit counter saturates on a pulse that never rises
        @(negedge clock); arm = 1'b1; pulse_in = 1'b0;
        @(negedge clock); arm = 1'b0;
        cyc = 0;
        while (!valid8 && cyc < 400) begin @(negedge clock); cyc++; end
        check("sat_done", 32'(valid8), 32'd1);
        check("sat_d8", 32'(d8), 32'd255);
        check("sat_w8", 32'(w8), 32'd0);
        check("sat_o8", 32'(ovf8), 32'd1);
        check("sat_busy16", 32'(busy16), 32'd1);
        reset_n = 1'b0;
        @(negedge clock); reset_n = 1'b1;
        @(negedge clock);

        // reset asserted while in the high phase aborts without a result
        @(negedge clock); arm = 1'b1; pulse_in = 1'b0;
        for (int k = 0; k < 20; k++) begin @(negedge clock); arm = 1'b0; end
        pulse_in = 1'b1;
        repeat (10) @(negedge clock);
        check("mid_busy", 32'(busy16), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy16 | busy8), 32'd0);
        check("abort_valid", 32'(valid16 | valid8), 32'd0);
        check("abort_cnt", 32'(d16) | 32'(w16), 32'd0);
        check("abort_ovf", 32'(ovf16), 32'd0);
        @(negedge clock); pulse_in = 1'b0; reset_n = 1'b1;
        @(negedge clock);
        build_ref(511, 15);
        measure("rerun511", 0);

        for (int t = 0; t < 8; t++) begin
            pat.delete();
            pat.push_back(1'($urandom_range(0, 1)));
            if (pat[0]) begin
                push_run(1'b1, $urandom_range(0, 5));
                push_run(1'b0, $urandom_range(1, 300));
            end else begin
                push_run(1'b0, $urandom_range(0, 300));
            end
            push_run(1'b1, $urandom_range(1, 300));
            pat.push_back(1'b0);
            measure($sformatf("rand%0d", t), (t == 3) ? 5 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
